// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader writing little-endian words into instruction memory
module imem_loader #(
    parameter int RegBits  = 32,
    parameter int AddrBits = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                byte_valid_i,
    input  logic [7:0]          byte_i,
    output logic                byte_ready_o,
    output logic                we_o,
    output logic [AddrBits-1:0] wa_o,
    output logic [RegBits-1:0]  wd_o,
    output logic                busy_o,
    output logic                hold_cpu_o,
    output logic                done_o,
    output logic                error_o
);
    localparam int BPW = RegBits / 8;

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, acc_q;
    logic [31:0]         n_q, n_full;
    logic [AddrBits:0]   addr_q;
    logic [RegBits-1:0]  asm_q, asm_d;
    logic                accept, start_ok, word_end, last_word, over;

    if (BPW == 1) begin : g_one
        assign asm_d = byte_i;
    end else begin : g_multi
        assign asm_d = {byte_i, asm_q[RegBits-1:8]};
    end

    assign busy_o       = state_q inside {LEN, DATA, CSUM};
    assign byte_ready_o = busy_o;
    assign hold_cpu_o   = busy_o;
    assign done_o       = state_q == DONE;
    assign error_o      = state_q == ERR;
    assign accept       = byte_valid_i && byte_ready_o;
    assign start_ok     = start_i && (state_q inside {IDLE, DONE, ERR});
    assign n_full       = {byte_i, n_q[31:8]};
    assign over         = {1'b0, n_full} > (33'd1 << AddrBits);
    assign word_end     = cnt_q == 8'(BPW - 1);
    // address counter is one bit wider so a full-memory image can be counted
    assign last_word    = 32'(addr_q) + 32'd1 == n_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: state_d = start_i ? LEN : state_q;
            LEN:  if (accept && cnt_q == 8'd3) state_d = over ? ERR : (n_full == '0 ? CSUM : DATA);
            DATA: if (accept && word_end && last_word) state_d = CSUM;
            CSUM: if (accept) state_d = byte_i == acc_q ? DONE : ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            n_q    <= '0;
            addr_q <= '0;
            asm_q  <= '0;
            we_o   <= 1'b0;
            wa_o   <= '0;
            wd_o   <= '0;
        end else begin
            we_o <= 1'b0;
            if (start_ok) begin
                cnt_q  <= '0;
                acc_q  <= '0;
                n_q    <= '0;
                addr_q <= '0;
            end else if (accept && state_q == LEN) begin
                n_q   <= n_full;
                cnt_q <= cnt_q == 8'd3 ? '0 : cnt_q + 8'd1;
            end else if (accept && state_q == DATA) begin
                asm_q <= asm_d;
                acc_q <= acc_q + byte_i;
                cnt_q <= word_end ? '0 : cnt_q + 8'd1;
                if (word_end) begin
                    we_o   <= 1'b1;
                    wa_o   <= addr_q[AddrBits-1:0];
                    wd_o   <= asm_d;
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for imem_loader with a write monitor
module tb_imem_loader;
    logic        clk = 0, rst_n = 0, start = 0, bvalid = 0;
    logic [7:0]  bdata = 0;
    logic        ready, we, busy, hold, done, err;
    logic [14:0] wa;
    logic [31:0] wd;

    int vectors = 0, miscompares = 0;
    int wr_cnt = 0;
    logic [14:0] wr_a [0:15];
    logic [31:0] wr_d [0:15];
    bit prev_we = 0, two_we = 0;
    logic [7:0] img [0:12];
    logic [7:0] lfsr = 8'h5a;

    imem_loader dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .byte_valid_i(bvalid), .byte_i(bdata),
        .byte_ready_o(ready), .we_o(we), .wa_o(wa), .wd_o(wd), .busy_o(busy),
        .hold_cpu_o(hold), .done_o(done), .error_o(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we && prev_we) two_we = 1;
        prev_we = we;
        if (we && wr_cnt < 16) begin
            wr_a[wr_cnt] = wa;
            wr_d[wr_cnt] = wd;
            wr_cnt = wr_cnt + 1;
        end
    end

    // payload 13 + 93 + 10 sums to B6
    task automatic set_img(input logic [7:0] cs);
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, cs};
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        bvalid = 1;
        bdata = b;
        k = 0;
        while (!ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        vectors++;
        if (!ready) begin
            miscompares++;
            $display("FAIL send_timeout: byte_ready stayed %b, want 1", ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic load_img(input int n, input bit throttle, input bit midstart);
        for (int i = 0; i < n; i++) begin
            if (throttle) begin
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                if (lfsr[0]) begin
                    bvalid = 0;
                    repeat (int'(lfsr[2:1]) + 1) @(posedge clk);
                    #1;
                end
            end
            if (midstart && i == 6) start = 1;
            send(img[i]);
            start = 0;
        end
        bvalid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if ({ready, we, busy, hold, done, err} !== 6'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 000000", {ready, we, busy, hold, done, err}); end
        vectors++; if (wa !== 15'h0 || wd !== 32'h0) begin miscompares++; $display("FAIL reset_bus: got wa=%h wd=%h want 0 0", wa, wd); end
        rst_n = 1;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_two_word();
        int b = wr_cnt;
        set_img(8'hB6);
        pulse_start();
        vectors++; if ({busy, hold, ready} !== 3'b111) begin miscompares++; $display("FAIL start_busy: got %b want 111", {busy, hold, ready}); end
        load_img(13, 0, 0);
        vectors++; if ({done, err, busy, hold, ready} !== 5'b10000) begin miscompares++; $display("FAIL two_word_end: got %b want 10000", {done, err, busy, hold, ready}); end
        vectors++; if (wr_cnt - b !== 2) begin miscompares++; $display("FAIL two_word_count: got %0d want 2", wr_cnt - b); end
        vectors++; if (wr_a[b] !== 15'd0 || wr_d[b] !== 32'h00000013) begin miscompares++; $display("FAIL two_word_w0: got %h/%h want 0/00000013", wr_a[b], wr_d[b]); end
        vectors++; if (wr_a[b+1] !== 15'd1 || wr_d[b+1] !== 32'h00100093) begin miscompares++; $display("FAIL two_word_w1: got %h/%h want 1/00100093", wr_a[b+1], wr_d[b+1]); end
        vectors++; if (we !== 1'b0 || wa !== 15'd1 || wd !== 32'h00100093) begin miscompares++; $display("FAIL hold_bus: got we=%b wa=%h wd=%h want 0 1 00100093", we, wa, wd); end
    endtask

    task automatic test_bad_csum();
        int b = wr_cnt;
        set_img(8'hA7);
        pulse_start();
        load_img(13, 0, 0);
        vectors++; if ({done, err, busy} !== 3'b010) begin miscompares++; $display("FAIL bad_csum_flags: got %b want 010", {done, err, busy}); end
        vectors++; if (wr_cnt - b !== 2) begin miscompares++; $display("FAIL bad_csum_writes: got %0d want 2", wr_cnt - b); end
        pulse_start();
        vectors++; if ({err, busy, ready} !== 3'b011) begin miscompares++; $display("FAIL err_restart: got %b want 011", {err, busy, ready}); end
    endtask

    task automatic test_empty();
        int b = wr_cnt;
        img[0:4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_img(5, 0, 0);
        vectors++; if ({done, err, busy} !== 3'b100) begin miscompares++; $display("FAIL empty_flags: got %b want 100", {done, err, busy}); end
        vectors++; if (wr_cnt - b !== 0) begin miscompares++; $display("FAIL empty_writes: got %0d want 0", wr_cnt - b); end
    endtask

    task automatic test_oversize();
        int b = wr_cnt;
        pulse_start();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_cleared: got %b want 0", done); end
        img[0:3] = '{8'h01, 8'h80, 8'h00, 8'h00};
        load_img(4, 0, 0);
        vectors++; if ({err, ready, busy, done} !== 4'b1000) begin miscompares++; $display("FAIL oversize_flags: got %b want 1000", {err, ready, busy, done}); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (wr_cnt - b !== 0) begin miscompares++; $display("FAIL oversize_writes: got %0d want 0", wr_cnt - b); end
    endtask

    task automatic test_throttled();
        int b = wr_cnt;
        set_img(8'hB6);
        pulse_start();
        load_img(13, 1, 1);
        vectors++; if ({done, err, busy} !== 3'b100) begin miscompares++; $display("FAIL throttle_flags: got %b want 100", {done, err, busy}); end
        vectors++; if (wr_cnt - b !== 2) begin miscompares++; $display("FAIL throttle_count: got %0d want 2", wr_cnt - b); end
        vectors++; if (wr_a[b] !== 15'd0 || wr_d[b] !== 32'h00000013) begin miscompares++; $display("FAIL throttle_w0: got %h/%h want 0/00000013", wr_a[b], wr_d[b]); end
        vectors++; if (wr_a[b+1] !== 15'd1 || wr_d[b+1] !== 32'h00100093) begin miscompares++; $display("FAIL throttle_w1: got %h/%h want 1/00100093", wr_a[b+1], wr_d[b+1]); end
    endtask

    task automatic test_reset_mid();
        int b;
        set_img(8'hB6);
        pulse_start();
        load_img(9, 0, 0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        vectors++; if ({ready, we, busy, hold, done, err} !== 6'b0) begin miscompares++; $display("FAIL midrst_flags: got %b want 000000", {ready, we, busy, hold, done, err}); end
        vectors++; if (wa !== 15'h0 || wd !== 32'h0) begin miscompares++; $display("FAIL midrst_bus: got wa=%h wd=%h want 0 0", wa, wd); end
        b = wr_cnt;
        pulse_start();
        load_img(13, 0, 0);
        vectors++; if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL reload_flags: got %b want 10", {done, err}); end
        vectors++; if (wr_cnt - b !== 2 || wr_a[b] !== 15'd0 || wr_d[b] !== 32'h00000013) begin miscompares++; $display("FAIL reload_w0: got n=%0d %h/%h want 2 0/00000013", wr_cnt - b, wr_a[b], wr_d[b]); end
        vectors++; if (two_we !== 1'b0) begin miscompares++; $display("FAIL we_consecutive: got %b want 0", two_we); end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_bad_csum();
        test_empty();
        test_oversize();
        test_throttled();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
